pipe_reg_skid: RTL

PIPE_REG_SKID -- requirements
Module: pipe_reg_skid

---
 rtl/pipe_pkg.sv | 16 +
 rtl/en_reg.sv | 30 +++
 rtl/pipe_reg_skid.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and FSM state type for the skid pipeline register
//
// Purpose: default payload width and the EMPTY/ONE/TWO state encoding.
// The encoding equals the number of held entries, so occupancy can be
// read straight from the state.
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 64;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/en_reg.sv
// rtl/en_reg.sv - enabled data register with synchronous active-low clear
//
// Purpose: WIDTH-bit register loaded with d when en is high. It is forced
// to RESET_VAL when clr_n is low, and clr_n has priority over en.
// Ports:
//   clk    in   clock, rising edge
//   clr_n  in   synchronous clear, active low
//   en     in   load enable
//   d      in   WIDTH  next value
//   q      out  WIDTH  registered value
module en_reg #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_reg_skid.sv
// rtl/pipe_reg_skid.sv - two-entry skid-buffered pipeline register with flush
//
// Purpose: full-throughput valid/ready register slice. in_ready depends
// only on local state, so no combinational path runs from out_ready back
// to in_ready. A second (skid) entry absorbs the word that arrives in the
// cycle the consumer stalls.
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   synchronous reset, active low
//   flush      in   synchronous discard of all held entries
//   in_valid   in   producer has in_data
//   in_ready   out  block accepts in_data this cycle
//   in_data    in   WIDTH  incoming payload
//   out_valid  out  out_data is a valid entry
//   out_ready  in   consumer takes out_data this cycle
//   out_data   out  WIDTH  oldest held payload
//   occupancy  out  2      held entries (0..2)
module pipe_reg_skid
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  state_e           state;
  state_e           state_nxt;
  logic             in_xfer;
  logic             out_xfer;
  logic             clr_n;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  // Both reset and flush clear the data registers back to RESET_VAL.
  assign clr_n     = reset_n && !flush;

  // in_ready is gated by reset and flush, so a flushed input never counts as a transfer.
  assign in_ready  = clr_n && (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state;

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    main_en   = 1'b0;
    main_d    = in_data;
    skid_en   = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_nxt = ONE;
          main_en   = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_en   = 1'b1;
        end else if (in_xfer) begin
          // Consumer stalled: park the new word behind main.
          state_nxt = TWO;
          skid_en   = 1'b1;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so skid is only drained and never written.
        if (out_xfer) begin
          state_nxt = ONE;
          main_en   = 1'b1;
          main_d    = skid_q;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // A same-cycle output transfer under flush still completes, because the
  // consumer has already sampled main. Going to EMPTY retires it.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  en_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  en_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule
